// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath (lw, sw, R-type, beq, j, addi).
// Control outputs are registered together with the state, so they change only on clock edges.
module multicycle_controller (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OPCODE,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       R_wbar,
    output logic       MemToReg,
    output logic       IRWrite,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] state_dbg,
    output logic       instr_done,
    output logic       illegal_op
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        REXEC = 4'd6, RCOMP = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcWriteCond;
        logic       pcWrite;
        logic       iorD;
        logic       rWbar;
        logic       memToReg;
        logic       irWrite;
        logic [1:0] pcSrc;
        logic [1:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       regWrite;
        logic       regDst;
        logic       instrDone;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{rWbar: 1'b1, default: '0};

    state_t state, nextState;
    ctrl_t  ctrl;
    logic   armed, isStore, legalOp;

    function automatic ctrl_t ctrlFor(state_t s);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            FETCH:          begin c.irWrite = 1'b1; c.aluSrcB = 2'b01; c.pcWrite = 1'b1; end
            DECODE:         c.aluSrcB = 2'b11;
            MEMADR, ADDIEX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            MEMRD:          c.iorD = 1'b1;
            MEMWB:          begin c.memToReg = 1'b1; c.regWrite = 1'b1; c.instrDone = 1'b1; end
            MEMWR:          begin c.iorD = 1'b1; c.rWbar = 1'b0; c.instrDone = 1'b1; end
            REXEC:          begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
            RCOMP:          begin c.regDst = 1'b1; c.regWrite = 1'b1; c.instrDone = 1'b1; end
            BRANCH: begin
                c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcWriteCond = 1'b1;
                c.pcSrc = 2'b01; c.instrDone = 1'b1;
            end
            JUMP:           begin c.pcWrite = 1'b1; c.pcSrc = 2'b10; c.instrDone = 1'b1; end
            ADDIWB:         begin c.regWrite = 1'b1; c.instrDone = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    assign legalOp = OPCODE inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    // The first edge after reset only loads FETCH outputs; the state is already FETCH.
    always_comb begin
        nextState = FETCH;
        if (armed)
            case (state)
                FETCH:  nextState = DECODE;
                DECODE: nextState = (OPCODE == OP_LW || OPCODE == OP_SW) ? MEMADR :
                                    (OPCODE == OP_RTYPE) ? REXEC :
                                    (OPCODE == OP_BEQ)   ? BRANCH :
                                    (OPCODE == OP_J)     ? JUMP :
                                    (OPCODE == OP_ADDI)  ? ADDIEX : FETCH;
                MEMADR: nextState = isStore ? MEMWR : MEMRD;
                MEMRD:  nextState = MEMWB;
                REXEC:  nextState = RCOMP;
                ADDIEX: nextState = ADDIWB;
                default: nextState = FETCH;
            endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= FETCH;
            ctrl    <= CTRL_IDLE;
            armed   <= 1'b0;
            isStore <= 1'b0;
        end else begin
            state <= nextState;
            ctrl  <= ctrlFor(nextState);
            armed <= 1'b1;
            if (state == DECODE) isStore <= (OPCODE == OP_SW);
        end
    end

    assign {PCWriteCond, PCWrite, IorD, R_wbar, MemToReg, IRWrite, PCSrc, ALUOp,
            ALUSrcA, ALUSrcB, RegWrite, RegDst, instr_done} = ctrl;
    assign state_dbg  = state;
    // OPCODE only becomes valid once IR has loaded, i.e. during DECODE itself.
    assign illegal_op = (state == DECODE) && !legalOp;
endmodule
